// File: rtl/pic_bus_buffer_seq_pkg.sv
// Shared types and constants for the 8259A data bus buffer: INTA state encoding,
// default CALL opcode and strobe edge-detect helpers.
package pic_bus_buffer_seq_pkg;

    localparam int unsigned DATA_W_DEF      = 8;
    localparam logic [7:0]  CALL_OPCODE_DEF = 8'hCD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_P1,
        ST_G1,
        ST_P2,
        ST_G2,
        ST_P3
    } inta_state_e;

    // Active-low strobe edges from the current level and its previous-cycle copy.
    function automatic logic fell(input logic cur, input logic prev);
        return prev & ~cur;
    endfunction

    function automatic logic rose(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/pic_bus_buffer_seq_if.sv
// CPU-side pin bundle of the 8259A data bus buffer.
interface pic_bus_buffer_seq_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic              cs_n;
    logic              rd_n;
    logic              wr_n;
    logic              a0;
    logic              inta_n;
    logic [DATA_W-1:0] d_in;
    logic [DATA_W-1:0] d_out;
    logic              d_oe;

    modport master (
        output cs_n, rd_n, wr_n, a0, inta_n, d_in,
        input  d_out, d_oe
    );

    modport slave (
        input  cs_n, rd_n, wr_n, a0, inta_n, d_in,
        output d_out, d_oe
    );
endinterface

// File: rtl/pic_bus_buffer_seq_inta_seq.sv
// INTA pulse sequencer: tracks 8080 (3 pulse) / 8086 (2 pulse) acknowledge cycles and
// presents the byte to load on each falling INTA edge.
module pic_inta_seq
    import pic_bus_buffer_seq_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter logic [7:0]  CALL_OPCODE = CALL_OPCODE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inta_n,
    input  logic              mode_8086,
    input  logic [DATA_W-1:0] vec_lo,
    input  logic [DATA_W-1:0] vec_hi,
    output logic              idle_c,
    output logic              load_c,
    output logic              drop_c,
    output logic              oe_c,
    output logic [DATA_W-1:0] byte_c,
    output logic              inta_first,
    output logic              inta_freeze,
    output logic              inta_done
);

    inta_state_e state;
    logic        inta_q;
    logic        mode_q;
    logic        inta_fall;
    logic        inta_rise;

    assign inta_fall = fell(inta_n, inta_q);
    assign inta_rise = rose(inta_n, inta_q);
    assign idle_c    = (state == ST_IDLE);

    // Byte to drive on a falling edge; vector inputs are sampled only here.
    always_comb begin
        load_c = 1'b0;
        drop_c = 1'b0;
        oe_c   = 1'b0;
        byte_c = '0;
        case (state)
            ST_IDLE: if (inta_fall) begin
                load_c = 1'b1;
                oe_c   = ~mode_8086;
                byte_c = mode_8086 ? '0 : DATA_W'(CALL_OPCODE);
            end
            ST_G1: if (inta_fall) begin
                load_c = 1'b1;
                oe_c   = 1'b1;
                byte_c = vec_lo;
            end
            ST_G2: if (inta_fall) begin
                load_c = 1'b1;
                oe_c   = 1'b1;
                byte_c = vec_hi;
            end
            ST_P1, ST_P2, ST_P3: drop_c = inta_rise;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        inta_q <= inta_n;
        if (rst) begin
            state       <= ST_IDLE;
            mode_q      <= 1'b0;
            inta_first  <= 1'b0;
            inta_freeze <= 1'b0;
            inta_done   <= 1'b0;
        end else begin
            inta_first <= 1'b0;
            inta_done  <= 1'b0;
            case (state)
                ST_IDLE: if (inta_fall) begin
                    state       <= ST_P1;
                    mode_q      <= mode_8086;
                    inta_first  <= 1'b1;
                    inta_freeze <= 1'b1;
                end
                ST_P1: if (inta_rise) state <= ST_G1;
                ST_G1: if (inta_fall) state <= ST_P2;
                ST_P2: if (inta_rise) begin
                    if (mode_q) begin
                        state       <= ST_IDLE;
                        inta_done   <= 1'b1;
                        inta_freeze <= 1'b0;
                    end else begin
                        state <= ST_G2;
                    end
                end
                ST_G2: if (inta_fall) state <= ST_P3;
                ST_P3: if (inta_rise) begin
                    state       <= ST_IDLE;
                    inta_done   <= 1'b1;
                    inta_freeze <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pic_bus_buffer_seq.sv
// 8259A data bus buffer: registers CPU read/write strobes, holds read data for the
// whole RD pulse, commits writes as single-cycle strobes and drives INTA vector bytes.
module pic_bus_buffer_seq
    import pic_bus_buffer_seq_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter logic [7:0]  CALL_OPCODE = CALL_OPCODE_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    pic_bus_buffer_seq_if.slave    bus,
    input  logic                   mode_8086,
    input  logic [DATA_W-1:0]      rd_data,
    input  logic [DATA_W-1:0]      vec_lo,
    input  logic [DATA_W-1:0]      vec_hi,
    output logic                   rd_a0,
    output logic                   rd_stb,
    output logic                   wr_stb,
    output logic                   wr_a0,
    output logic [DATA_W-1:0]      wr_data,
    output logic                   inta_first,
    output logic                   inta_freeze,
    output logic                   inta_done
);

    logic              rd_q;
    logic              wr_q;
    logic              rd_active;
    logic              wr_sel;
    logic              cap_a0;
    logic [DATA_W-1:0] cap_data;
    logic              idle_c;
    logic              load_c;
    logic              drop_c;
    logic              oe_c;
    logic [DATA_W-1:0] byte_c;
    logic              wr_low;
    logic              wr_rise;
    logic              rd_fall;
    logic              rd_end;

    pic_inta_seq #(
        .DATA_W      (DATA_W),
        .CALL_OPCODE (CALL_OPCODE)
    ) u_inta_seq (
        .clk         (clk),
        .rst         (rst),
        .inta_n      (bus.inta_n),
        .mode_8086   (mode_8086),
        .vec_lo      (vec_lo),
        .vec_hi      (vec_hi),
        .idle_c      (idle_c),
        .load_c      (load_c),
        .drop_c      (drop_c),
        .oe_c        (oe_c),
        .byte_c      (byte_c),
        .inta_first  (inta_first),
        .inta_freeze (inta_freeze),
        .inta_done   (inta_done)
    );

    // A simultaneous write or any INTA activity pre-empts a CPU read.
    assign wr_low  = ~bus.cs_n & ~bus.wr_n;
    assign wr_rise = rose(bus.wr_n, wr_q);
    assign rd_fall = ~bus.cs_n & fell(bus.rd_n, rd_q) & bus.wr_n & idle_c & ~load_c;
    assign rd_end  = bus.rd_n | wr_low | ~idle_c | load_c;

    always_ff @(posedge clk) begin
        rd_q <= bus.rd_n;
        wr_q <= bus.wr_n;
        if (rst) begin
            rd_active <= 1'b0;
            wr_sel    <= 1'b0;
            cap_a0    <= 1'b0;
            cap_data  <= '0;
            rd_a0     <= 1'b0;
            rd_stb    <= 1'b0;
            wr_stb    <= 1'b0;
            wr_a0     <= 1'b0;
            wr_data   <= '0;
            bus.d_out <= '0;
            bus.d_oe  <= 1'b0;
        end else begin
            rd_stb <= rd_fall;
            wr_stb <= 1'b0;
            if (rd_fall) rd_a0 <= bus.a0;

            if (wr_low) begin
                cap_data <= bus.d_in;
                cap_a0   <= bus.a0;
                if (wr_q) wr_sel <= 1'b1;
            end
            if (wr_rise && wr_sel) begin
                wr_stb  <= 1'b1;
                wr_data <= cap_data;
                wr_a0   <= cap_a0;
                wr_sel  <= 1'b0;
            end

            if (rd_fall)     rd_active <= 1'b1;
            else if (rd_end) rd_active <= 1'b0;

            // INTA bytes override read data; read data is captured once, then held.
            if (load_c) begin
                bus.d_out <= byte_c;
                bus.d_oe  <= oe_c;
            end else if (drop_c) begin
                bus.d_oe <= 1'b0;
            end else if (idle_c && rd_active) begin
                if (rd_end) begin
                    bus.d_oe <= 1'b0;
                end else if (rd_stb) begin
                    bus.d_out <= rd_data;
                    bus.d_oe  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pic_bus_buffer_seq.sv
// Directed self-checking bench for pic_bus_buffer_seq.
module tb_pic_bus_buffer_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode_8086;
    logic [7:0] rd_data, vec_lo, vec_hi;
    logic       rd_a0, rd_stb, wr_stb, wr_a0;
    logic [7:0] wr_data;
    logic       inta_first, inta_freeze, inta_done;
    int         checks = 0;
    int         errors = 0;

    pic_bus_buffer_seq_if #(.DATA_W(8)) bus ();

    pic_bus_buffer_seq #(.DATA_W(8), .CALL_OPCODE(8'hCD)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .mode_8086   (mode_8086),
        .rd_data     (rd_data),
        .vec_lo      (vec_lo),
        .vec_hi      (vec_hi),
        .rd_a0       (rd_a0),
        .rd_stb      (rd_stb),
        .wr_stb      (wr_stb),
        .wr_a0       (wr_a0),
        .wr_data     (wr_data),
        .inta_first  (inta_first),
        .inta_freeze (inta_freeze),
        .inta_done   (inta_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.cs_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1;
        bus.a0 = 1'b0; bus.inta_n = 1'b1; bus.d_in = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode_8086 = 1'b0; rd_data = 8'h00; vec_lo = 8'h00; vec_hi = 8'h00;
        bus_idle();
        tick(); tick();
        checks++; if (bus.d_oe !== 1'b0) begin errors++; $display("FAIL reset_d_oe got %h exp 0", bus.d_oe); end
        checks++; if (bus.d_out !== 8'h00) begin errors++; $display("FAIL reset_d_out got %h exp 00", bus.d_out); end
        checks++; if ({rd_stb, wr_stb, inta_first, inta_freeze, inta_done} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes got %b exp 00000", {rd_stb, wr_stb, inta_first, inta_freeze, inta_done}); end
        checks++; if ({wr_data, wr_a0, rd_a0} !== 10'h0) begin errors++; $display("FAIL reset_wr got %h exp 000", {wr_data, wr_a0, rd_a0}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read();
        bus.cs_n = 1'b0; bus.rd_n = 1'b0; bus.a0 = 1'b1; rd_data = 8'h5A;
        tick();
        checks++; if (rd_stb !== 1'b1) begin errors++; $display("FAIL read_stb got %h exp 1", rd_stb); end
        checks++; if (rd_a0 !== 1'b1) begin errors++; $display("FAIL read_a0 got %h exp 1", rd_a0); end
        checks++; if (bus.d_oe !== 1'b0) begin errors++; $display("FAIL read_oe_n1 got %h exp 0", bus.d_oe); end
        tick();
        rd_data = 8'h00;
        checks++; if (rd_stb !== 1'b0) begin errors++; $display("FAIL read_stb_once got %h exp 0", rd_stb); end
        checks++; if ({bus.d_oe, bus.d_out} !== 9'h15A) begin errors++; $display("FAIL read_drive got %h exp 15A", {bus.d_oe, bus.d_out}); end
        tick(); tick();
        checks++; if ({bus.d_oe, bus.d_out, rd_stb} !== {9'h15A, 1'b0}) begin
            errors++; $display("FAIL read_hold got %h exp 2b4", {bus.d_oe, bus.d_out, rd_stb}); end
        bus.rd_n = 1'b1; bus.cs_n = 1'b1;
        checks++; if (bus.d_oe !== 1'b1) begin errors++; $display("FAIL read_oe_at_rise got %h exp 1", bus.d_oe); end
        tick();
        checks++; if (bus.d_oe !== 1'b0) begin errors++; $display("FAIL read_oe_drop got %h exp 0", bus.d_oe); end
    endtask

    task automatic test_write();
        logic [8:0] vecs [2];
        vecs[0] = {1'b0, 8'h13};
        vecs[1] = {1'b1, 8'hA7};
        for (int i = 0; i < 2; i++) begin
            bus.cs_n = 1'b0; bus.wr_n = 1'b0; bus.a0 = vecs[i][8]; bus.d_in = vecs[i][7:0];
            tick();
            checks++; if (wr_stb !== 1'b0) begin errors++; $display("FAIL write_early_stb[%0d] got %h exp 0", i, wr_stb); end
            tick();
            bus.wr_n = 1'b1;
            tick();
            checks++; if ({wr_stb, wr_a0, wr_data} !== {1'b1, vecs[i]}) begin
                errors++; $display("FAIL write_commit[%0d] got %h exp %h", i, {wr_stb, wr_a0, wr_data}, {1'b1, vecs[i]}); end
            bus.cs_n = 1'b1;
            tick();
            checks++; if (wr_stb !== 1'b0) begin errors++; $display("FAIL write_single[%0d] got %h exp 0", i, wr_stb); end
        end
        bus_idle();
    endtask

    task automatic test_inta_8080();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'hCD; exp_b[1] = 8'h20; exp_b[2] = 8'h01;
        mode_8086 = 1'b0; vec_lo = 8'h20; vec_hi = 8'h01;
        for (int p = 0; p < 3; p++) begin
            bus.inta_n = 1'b0;
            tick();
            vec_lo = 8'hEE; vec_hi = 8'hFF;
            checks++; if ({bus.d_oe, bus.d_out} !== {1'b1, exp_b[p]}) begin
                errors++; $display("FAIL i8080_byte[%0d] got %h exp %h", p, {bus.d_oe, bus.d_out}, {1'b1, exp_b[p]}); end
            checks++; if (inta_first !== (p == 0)) begin errors++; $display("FAIL i8080_first[%0d] got %h", p, inta_first); end
            tick();
            checks++; if ({bus.d_out, inta_first, inta_freeze} !== {exp_b[p], 2'b01}) begin
                errors++; $display("FAIL i8080_hold[%0d] got %h exp %h", p, {bus.d_out, inta_first, inta_freeze}, {exp_b[p], 2'b01}); end
            vec_lo = 8'h20; vec_hi = 8'h01;
            bus.inta_n = 1'b1;
            tick();
            checks++; if ({bus.d_oe, inta_freeze, inta_done} !== {1'b0, (p != 2), (p == 2)}) begin
                errors++; $display("FAIL i8080_rise[%0d] got %b", p, {bus.d_oe, inta_freeze, inta_done}); end
            tick();
        end
        checks++; if ({inta_done, inta_freeze} !== 2'b00) begin errors++; $display("FAIL i8080_done_pulse got %b exp 00", {inta_done, inta_freeze}); end
    endtask

    task automatic test_inta_8086();
        mode_8086 = 1'b1; vec_lo = 8'h4B;
        bus.inta_n = 1'b0;
        tick();
        mode_8086 = 1'b0;
        checks++; if ({bus.d_oe, inta_first, inta_freeze} !== 3'b011) begin
            errors++; $display("FAIL i8086_p1 got %b exp 011", {bus.d_oe, inta_first, inta_freeze}); end
        bus.inta_n = 1'b1;
        tick(); tick();
        bus.inta_n = 1'b0;
        tick();
        checks++; if ({bus.d_oe, bus.d_out} !== 9'h14B) begin errors++; $display("FAIL i8086_vec got %h exp 14B", {bus.d_oe, bus.d_out}); end
        bus.inta_n = 1'b1;
        tick();
        checks++; if ({bus.d_oe, inta_freeze, inta_done} !== 3'b001) begin
            errors++; $display("FAIL i8086_end got %b exp 001", {bus.d_oe, inta_freeze, inta_done}); end
        tick();
    endtask

    task automatic test_reset_mid();
        mode_8086 = 1'b0; vec_lo = 8'h66;
        bus.inta_n = 1'b0; tick();
        bus.inta_n = 1'b1; tick();
        bus.inta_n = 1'b0; tick();
        checks++; if ({bus.d_oe, bus.d_out} !== 9'h166) begin errors++; $display("FAIL rmid_pre got %h exp 166", {bus.d_oe, bus.d_out}); end
        rst = 1'b1; tick(); tick();
        checks++; if ({bus.d_oe, bus.d_out, inta_freeze, inta_done} !== 11'h0) begin
            errors++; $display("FAIL rmid_reset got %h exp 000", {bus.d_oe, bus.d_out, inta_freeze, inta_done}); end
        rst = 1'b0; tick();
        bus.inta_n = 1'b1; tick();
        checks++; if ({inta_done, inta_freeze, bus.d_oe} !== 3'b000) begin
            errors++; $display("FAIL rmid_no_done got %b exp 000", {inta_done, inta_freeze, bus.d_oe}); end
        bus.inta_n = 1'b0; tick();
        checks++; if ({inta_first, bus.d_oe, bus.d_out} !== 10'h3CD) begin
            errors++; $display("FAIL rmid_idle got %h exp 3CD", {inta_first, bus.d_oe, bus.d_out}); end
        bus.inta_n = 1'b1; rst = 1'b1; tick();
        rst = 1'b0; tick();
    endtask

    task automatic test_read_priority();
        mode_8086 = 1'b0; vec_lo = 8'h31; rd_data = 8'h77;
        bus.cs_n = 1'b0; bus.rd_n = 1'b0; bus.a0 = 1'b0;
        tick(); tick();
        checks++; if ({bus.d_oe, bus.d_out} !== 9'h177) begin errors++; $display("FAIL prio_read got %h exp 177", {bus.d_oe, bus.d_out}); end
        bus.inta_n = 1'b0; tick();
        checks++; if ({bus.d_oe, bus.d_out} !== 9'h1CD) begin errors++; $display("FAIL prio_preempt got %h exp 1CD", {bus.d_oe, bus.d_out}); end
        bus.inta_n = 1'b1; bus.rd_n = 1'b1; tick();
        bus.rd_n = 1'b0; tick();
        checks++; if ({rd_stb, bus.d_oe} !== 2'b00) begin errors++; $display("FAIL prio_g1_read got %b exp 00", {rd_stb, bus.d_oe}); end
        bus.rd_n = 1'b1; bus.wr_n = 1'b0; bus.a0 = 1'b1; bus.d_in = 8'h5E; tick();
        bus.wr_n = 1'b1; tick();
        checks++; if ({wr_stb, wr_a0, wr_data, inta_freeze} !== {2'b11, 8'h5E, 1'b1}) begin
            errors++; $display("FAIL prio_g1_write got %h", {wr_stb, wr_a0, wr_data, inta_freeze}); end
        bus.cs_n = 1'b1; bus.inta_n = 1'b0; tick();
        checks++; if ({bus.d_oe, bus.d_out} !== 9'h131) begin errors++; $display("FAIL prio_seq_cont got %h exp 131", {bus.d_oe, bus.d_out}); end
        bus_idle(); rst = 1'b1; tick();
        rst = 1'b0; tick();
    endtask

    task automatic test_rw_conflict();
        bus.cs_n = 1'b0; bus.rd_n = 1'b0; bus.wr_n = 1'b0; bus.a0 = 1'b1; bus.d_in = 8'h3C; rd_data = 8'h99;
        tick();
        checks++; if ({rd_stb, bus.d_oe} !== 2'b00) begin errors++; $display("FAIL rw_no_read got %b exp 00", {rd_stb, bus.d_oe}); end
        tick();
        bus.rd_n = 1'b1; bus.wr_n = 1'b1;
        tick();
        checks++; if ({wr_stb, wr_a0, wr_data, rd_stb, bus.d_oe} !== {2'b11, 8'h3C, 2'b00}) begin
            errors++; $display("FAIL rw_commit got %h", {wr_stb, wr_a0, wr_data, rd_stb, bus.d_oe}); end
        bus_idle(); tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_inta_8080();
        test_inta_8086();
        test_reset_mid();
        test_read_priority();
        test_rw_conflict();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
